pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Instruction sequencer for the 12-bit-instruction Mini-CPU core. It owns the program counter, the instruction register and the two-level hardware call stack, and runs the two-stage fetch/execute pipeline. It resolves GOTO, CALL, RETLW, computed jumps through PCL, conditional skips and SLEEP/wake. It consumes the instruction decoder's flags for the instruction held in `ir`. Its `exec_valid` output gates every datapath write enable.

## Interface
- `PC_W`, 9, program counter / program address width.
- `RESET_VEC`, `{PC_W{1'b1}}`, PC value loaded on reset.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `instr_in`  in  12  program memory data at `prog_addr`, valid in the same cycle.
- `prog_addr`  out  PC_W  program memory address; equals `pc`.
- `ir`  out  12  instruction currently in the execute stage.
- `exec_valid`  out  1  `ir` is executed this cycle; the datapath must ignore `ir` when this is 0.
- `GOTO`, `CALL`, `RETLW`, `SLEEP`, `FSZ`, `BTFSS`  in  1 each  decoder flags for `ir`.
- `alu_zero`  in  1  the ALU result of the executing instruction is 8'h00.
- `pcl_wr`  in  1  the datapath writes PCL (file address 2) this cycle.
- `pcl_data`  in  8  value written to PCL.
- `wake`  in  1  wake request (WDT timeout or port change); sampled only while sleeping.
- `sleeping`  out  1  core is in SLEEP.
- `stack_top`  out  PC_W  `stack0`, for debug and trace.

## Operation
- State: `pc`, `ir`, `ir_valid` (drives `exec_valid`), `stack0`, `stack1`, and mode RUN/SLP.
- Reset values:
  - `pc` = RESET_VEC
  - `ir` = 12'h000
  - `ir_valid` = 0
  - `stack0` = `stack1` = 0
  - mode = RUN, `sleeping` = 0
- In RUN, every cycle loads `ir <= instr_in`. `pc` and `ir_valid` update per the first matching rule below. `exec` means `ir_valid` = 1.
  - `!exec`: `pc <= pc+1`, `ir_valid <= 1`. This is the fill cycle.
  - `exec && GOTO`: `pc <= ir[PC_W-1:0]`, `ir_valid <= 0`.
  - `exec && CALL`:
    - `stack1 <= stack0`, `stack0 <= pc`. `pc` is already the return address.
    - `pc <= {0, ir[7:0]}`, `ir_valid <= 0`.
  - `exec && RETLW`: `pc <= stack0`, `stack0 <= stack1`, `stack1` unchanged, `ir_valid <= 0`.
  - `exec && pcl_wr`: `pc <= {0, pcl_data}`, `ir_valid <= 0`. This rule also beats a skip condition in the same cycle.
  - Skip, `exec && ((FSZ && alu_zero) || (BTFSS && !alu_zero))`: `pc <= pc+1`, `ir_valid <= 0`. The fetched instruction is discarded.
  - `exec && SLEEP`: mode <= SLP, `pc` held, `ir_valid <= 0`.
  - Otherwise: `pc <= pc+1`, `ir_valid <= 1`.
- SLP mode:
  - `pc`, `ir` and the stack are held; `ir_valid` = 0; `sleeping` = 1.
  - `wake` = 1 in any SLP cycle sets mode <= RUN at the next edge. Execution then resumes with a fill cycle at the address after SLEEP.
- Stack overflow: a third nested CALL silently loses the oldest entry.
- Stack underflow: RETLW beyond the depth keeps returning to `stack1`.
- `pc+1` wraps modulo 2^PC_W.
- Decoder flags are ignored when `exec_valid` = 0.

## Timing
- Two-stage pipeline. An instruction fetched in cycle N executes in cycle N+1 while the instruction at `pc` is fetched.
- Straight-line code: one instruction per cycle.
- Taken GOTO, CALL, RETLW, PCL write and skip: 2 cycles, with one bubble (`exec_valid` = 0).
- First `exec_valid` = 1 occurs in the second cycle after `rst_n` deasserts. That instruction is the one at RESET_VEC.
- SLEEP: `sleeping` rises one cycle after SLEEP executes.
- Wake:
  - `sleeping` falls one cycle after `wake` is sampled.
  - The instruction after SLEEP executes 2 cycles after `wake` is sampled.
- Asynchronous reset in any state or mid-branch immediately restores all reset values. No partial stack push or pop survives.

## Test plan
- Reset then straight-line NOPs:
  - `prog_addr` = 0x1FF, 0x000, 0x001, …
  - `exec_valid` = 0 then 1.
  - The wrap from 0x1FF to 0x000 is checked.
- GOTO 0x0A5 at address 0x010 → next `prog_addr` = 0x0A5, one bubble, then the instruction at 0x0A5 executes.
- CALL 0x40 at 0x020, nested CALL 0x60 at 0x041, then a third CALL at 0x061. After that, RETLW ×3:
  - first return → 0x062
  - second return → 0x042
  - third return → 0x042
- DECFSZ:
  - With `alu_zero` = 1: the instruction at PC+1 is skipped with `exec_valid` = 0, and execution resumes at PC+2.
  - With `alu_zero` = 0: no bubble.
  - BTFSS checked with the opposite polarity.
- `pcl_wr` = 1 with `pcl_data` = 0x33 together with a skip condition → `pc` = 0x033, one bubble.
- SLEEP at 0x050:
  - `sleeping` = 1, `prog_addr` held at 0x051 for 10 cycles.
  - Pulse `wake` → the instruction at 0x051 executes 2 cycles later.
  - Asserting `rst_n` = 0 during SLP returns `pc` to 0x1FF and `sleeping` to 0.

Source files
------------

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer_if
// Description : Bus bundle between the instruction sequencer and the program
//               memory, instruction decoder and datapath of the Mini-CPU.
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_sequencer_if #(
    parameter int PC_W = 9
);
    logic [11:0]     instr_in;
    logic [PC_W-1:0] prog_addr;
    logic [11:0]     ir;
    logic            exec_valid;
    logic            GOTO;
    logic            CALL;
    logic            RETLW;
    logic            SLEEP;
    logic            FSZ;
    logic            BTFSS;
    logic            alu_zero;
    logic            pcl_wr;
    logic [7:0]      pcl_data;
    logic            wake;
    logic            sleeping;
    logic [PC_W-1:0] stack_top;

    modport master (
        input  instr_in,
        input  GOTO, CALL, RETLW, SLEEP, FSZ, BTFSS,
        input  alu_zero, pcl_wr, pcl_data, wake,
        output prog_addr, ir, exec_valid, sleeping, stack_top
    );

    modport slave (
        output instr_in,
        output GOTO, CALL, RETLW, SLEEP, FSZ, BTFSS,
        output alu_zero, pcl_wr, pcl_data, wake,
        input  prog_addr, ir, exec_valid, sleeping, stack_top
    );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Fetch/execute sequencer: program counter, instruction register,
//               two-level call stack, branches, skips and SLEEP/wake.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter int              PC_W      = 9,
    parameter logic [PC_W-1:0] RESET_VEC = {PC_W{1'b1}}
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    pc_sequencer_if.master    bus
);

    typedef enum logic [0:0] {
        MODE_RUN = 1'b0,
        MODE_SLP = 1'b1
    } mode_e;

    localparam logic [PC_W-1:0] c_pc_one = PC_W'(1);

    mode_e           mode_q, mode_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [11:0]     ir_q, ir_d;
    logic            ir_valid_q, ir_valid_d;
    logic [PC_W-1:0] stack0_q, stack0_d;
    logic [PC_W-1:0] stack1_q, stack1_d;
    logic            sleeping_q, sleeping_d;

    logic [PC_W-1:0] w_pc_inc;
    logic            w_skip;

    assign w_pc_inc = pc_q + c_pc_one;
    assign w_skip   = (bus.FSZ & bus.alu_zero) | (bus.BTFSS & ~bus.alu_zero);

    // Rules are evaluated in strict priority; pc already points at the
    // return address while the CALL sits in ir.
    always_comb begin
        mode_d     = mode_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        stack0_d   = stack0_q;
        stack1_d   = stack1_q;

        if (mode_q == MODE_RUN) begin
            ir_d = bus.instr_in;
            if (!ir_valid_q) begin
                pc_d       = w_pc_inc;
                ir_valid_d = 1'b1;
            end else if (bus.GOTO) begin
                pc_d       = ir_q[PC_W-1:0];
                ir_valid_d = 1'b0;
            end else if (bus.CALL) begin
                stack1_d   = stack0_q;
                stack0_d   = pc_q;
                pc_d       = PC_W'(ir_q[7:0]);
                ir_valid_d = 1'b0;
            end else if (bus.RETLW) begin
                pc_d       = stack0_q;
                stack0_d   = stack1_q;
                ir_valid_d = 1'b0;
            end else if (bus.pcl_wr) begin
                pc_d       = PC_W'(bus.pcl_data);
                ir_valid_d = 1'b0;
            end else if (w_skip) begin
                pc_d       = w_pc_inc;
                ir_valid_d = 1'b0;
            end else if (bus.SLEEP) begin
                mode_d     = MODE_SLP;
                ir_valid_d = 1'b0;
            end else begin
                pc_d       = w_pc_inc;
                ir_valid_d = 1'b1;
            end
        end else begin
            // Leaving SLP with ir_valid low forces a fill cycle at pc.
            ir_valid_d = 1'b0;
            if (bus.wake) begin
                mode_d = MODE_RUN;
            end
        end

        sleeping_d = (mode_d == MODE_SLP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= MODE_RUN;
            pc_q       <= RESET_VEC;
            ir_q       <= 12'h000;
            ir_valid_q <= 1'b0;
            stack0_q   <= '0;
            stack1_q   <= '0;
            sleeping_q <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            stack0_q   <= stack0_d;
            stack1_q   <= stack1_d;
            sleeping_q <= sleeping_d;
        end
    end

    assign bus.prog_addr  = pc_q;
    assign bus.ir         = ir_q;
    assign bus.exec_valid = ir_valid_q;
    assign bus.sleeping   = sleeping_q;
    assign bus.stack_top  = stack0_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Directed program walk plus randomized run of pc_sequencer
//               against a queue-based behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    localparam int PC_W = 9;

    localparam int K_NOP     = 0;
    localparam int K_GOTO    = 1;
    localparam int K_CALL    = 2;
    localparam int K_RET     = 3;
    localparam int K_SLEEP   = 4;
    localparam int K_FSZ     = 5;
    localparam int K_BTFSS   = 6;
    localparam int K_PCL     = 7;
    localparam int K_PCLSKIP = 8;
    localparam int K_RAND    = 9;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    pc_sequencer_if #(.PC_W(PC_W)) bus();

    pc_sequencer #(.PC_W(PC_W), .RESET_VEC(9'h1FF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [11:0] mem  [512];
    int          kind [512];
    logic        az   [512];

    assign bus.instr_in = mem[bus.prog_addr];

    // Reference model state: fetch address, executing word, stack as a queue.
    logic [8:0]  m_pc;
    logic [11:0] m_ir;
    logic        m_valid;
    logic        m_slp;
    logic [8:0]  m_exec_addr;
    logic [8:0]  m_stk [$];

    int   total = 0;
    int   bad   = 0;
    logic rand_mode  = 1'b0;
    logic wake_force = 1'b0;
    int   pend = 0;
    logic [8:0] goto_log [$];
    logic [8:0] ret_log  [$];
    logic [8:0] pcl_log  [$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc        = 9'h1FF;
        m_ir        = 12'h000;
        m_valid     = 1'b0;
        m_slp       = 1'b0;
        m_exec_addr = 9'h000;
        m_stk       = '{9'h000, 9'h000};
        pend        = 0;
    endtask

    task automatic drive();
        logic ex;
        ex = m_valid && !m_slp;
        {bus.GOTO, bus.CALL, bus.RETLW, bus.SLEEP, bus.FSZ, bus.BTFSS, bus.pcl_wr} = 7'($urandom);
        bus.alu_zero = 1'($urandom);
        bus.pcl_data = 8'($urandom);
        pend = 0;
        if (ex) begin
            {bus.GOTO, bus.CALL, bus.RETLW, bus.SLEEP, bus.FSZ, bus.BTFSS, bus.pcl_wr} = 7'd0;
            bus.alu_zero = rand_mode ? 1'($urandom) : az[m_exec_addr];
            bus.pcl_data = mem[m_exec_addr][7:0];
            case (kind[m_exec_addr])
                K_GOTO:    begin bus.GOTO  = 1'b1; pend = 1; end
                K_CALL:    bus.CALL  = 1'b1;
                K_RET:     begin bus.RETLW = 1'b1; pend = 2; end
                K_SLEEP:   bus.SLEEP = 1'b1;
                K_FSZ:     bus.FSZ   = 1'b1;
                K_BTFSS:   bus.BTFSS = 1'b1;
                K_PCL:     bus.pcl_wr = 1'b1;
                K_PCLSKIP: begin bus.pcl_wr = 1'b1; bus.FSZ = 1'b1; pend = 3; end
                K_RAND:    {bus.GOTO, bus.CALL, bus.RETLW, bus.SLEEP, bus.FSZ, bus.BTFSS, bus.pcl_wr} = 7'($urandom);
                default:   ;
            endcase
        end
        bus.wake = wake_force | (rand_mode && ($urandom_range(0, 5) == 0));
    endtask

    task automatic model_update();
        logic [8:0] fa;
        if (!m_slp) begin
            fa = m_pc;
            if (!m_valid) begin
                m_pc = m_pc + 9'd1;  m_valid = 1'b1;
            end else if (bus.GOTO) begin
                m_pc = m_ir[8:0];    m_valid = 1'b0;
            end else if (bus.CALL) begin
                m_stk.push_front(m_pc);
                void'(m_stk.pop_back());
                m_pc = {1'b0, m_ir[7:0]};
                m_valid = 1'b0;
            end else if (bus.RETLW) begin
                m_pc  = m_stk[0];
                m_stk = '{m_stk[1], m_stk[1]};
                m_valid = 1'b0;
            end else if (bus.pcl_wr) begin
                m_pc = {1'b0, bus.pcl_data};  m_valid = 1'b0;
            end else if ((bus.FSZ && bus.alu_zero) || (bus.BTFSS && !bus.alu_zero)) begin
                m_pc = m_pc + 9'd1;  m_valid = 1'b0;
            end else if (bus.SLEEP) begin
                m_slp = 1'b1;        m_valid = 1'b0;
            end else begin
                m_pc = m_pc + 9'd1;  m_valid = 1'b1;
            end
            m_ir        = mem[fa];
            m_exec_addr = fa;
        end else if (bus.wake) begin
            m_slp = 1'b0;
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step();
        check_val("prog_addr",  32'(bus.prog_addr),  32'(m_pc));
        check_val("exec_valid", 32'(bus.exec_valid), 32'(m_valid));
        check_val("ir",         32'(bus.ir),         32'(m_ir));
        check_val("sleeping",   32'(bus.sleeping),   32'(m_slp));
        check_val("stack_top",  32'(bus.stack_top),  32'(m_stk[0]));
        drive();
        model_update();
        @(negedge clk);
        if (!rand_mode) begin
            case (pend)
                1: goto_log.push_back(bus.prog_addr);
                2: ret_log.push_back(bus.prog_addr);
                3: pcl_log.push_back(bus.prog_addr);
                default: ;
            endcase
        end
    endtask

    task automatic apply_reset();
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_pc",       32'(bus.prog_addr),  32'h1FF);
        check_val("rst_valid",    32'(bus.exec_valid), 32'h0);
        check_val("rst_sleeping", 32'(bus.sleeping),   32'h0);
        check_val("rst_stack",    32'(bus.stack_top),  32'h0);
        check_val("rst_ir",       32'(bus.ir),         32'h0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_log(input string tag, input logic [8:0] q [$], input int idx, input logic [8:0] exp);
        if (q.size() > idx) check_val(tag, 32'(q[idx]), 32'(exp));
        else                check_val({tag, "_missing"}, 32'(q.size()), 32'(idx + 1));
    endtask

    initial begin
        int n;
        int r;
        {bus.GOTO, bus.CALL, bus.RETLW, bus.SLEEP, bus.FSZ, bus.BTFSS, bus.pcl_wr} = 7'd0;
        bus.alu_zero = 1'b0;
        bus.pcl_data = 8'h00;
        bus.wake     = 1'b0;
        for (int i = 0; i < 512; i++) begin
            mem[i] = 12'h000; kind[i] = K_NOP; az[i] = 1'b0;
        end
        mem[9'h010] = 12'h0A5; kind[9'h010] = K_GOTO;
        mem[9'h0A5] = 12'h020; kind[9'h0A5] = K_GOTO;
        mem[9'h020] = 12'h040; kind[9'h020] = K_CALL;
        mem[9'h041] = 12'h060; kind[9'h041] = K_CALL;
        mem[9'h061] = 12'h070; kind[9'h061] = K_CALL;
        kind[9'h070] = K_RET;
        kind[9'h062] = K_RET;
        kind[9'h042] = K_RET;
        kind[9'h044] = K_FSZ;   az[9'h044] = 1'b1;
        kind[9'h046] = K_FSZ;   az[9'h046] = 1'b0;
        kind[9'h047] = K_BTFSS; az[9'h047] = 1'b0;
        kind[9'h049] = K_BTFSS; az[9'h049] = 1'b1;
        mem[9'h04A] = 12'h033; kind[9'h04A] = K_PCLSKIP; az[9'h04A] = 1'b1;
        mem[9'h033] = 12'h050; kind[9'h033] = K_GOTO;
        kind[9'h050] = K_SLEEP;
        mem[9'h051] = 12'hABC;
        kind[9'h052] = K_SLEEP;

        @(negedge clk);
        apply_reset();
        check_val("first_pc", 32'(bus.prog_addr), 32'h1FF);
        step();
        check_val("wrap_pc",    32'(bus.prog_addr),  32'h000);
        check_val("first_exec", 32'(bus.exec_valid), 32'h1);

        n = 0;
        while (ret_log.size() < 3 && n < 400) begin step(); n++; end
        kind[9'h042] = K_NOP;
        n = 0;
        while (!bus.sleeping && n < 400) begin step(); n++; end
        check_val("sleep_reached", 32'(bus.sleeping), 32'h1);

        check_log("goto_tgt", goto_log, 0, 9'h0A5);
        check_log("ret1", ret_log, 0, 9'h062);
        check_log("ret2", ret_log, 1, 9'h042);
        check_log("ret3", ret_log, 2, 9'h042);
        check_log("pcl_tgt", pcl_log, 0, 9'h033);

        for (int i = 0; i < 10; i++) begin
            check_val("slp_hold_pc", 32'(bus.prog_addr), 32'h051);
            check_val("slp_flag",    32'(bus.sleeping),  32'h1);
            step();
        end
        wake_force = 1'b1;
        step();
        wake_force = 1'b0;
        check_val("wake_sleep_fall", 32'(bus.sleeping),   32'h0);
        check_val("wake_fill",       32'(bus.exec_valid), 32'h0);
        step();
        check_val("wake_exec_valid", 32'(bus.exec_valid), 32'h1);
        check_val("wake_exec_ir",    32'(bus.ir),         32'hABC);

        n = 0;
        while (!bus.sleeping && n < 50) begin step(); n++; end
        check_val("sleep2_reached", 32'(bus.sleeping), 32'h1);
        apply_reset();
        for (int i = 0; i < 4; i++) step();

        // Randomized phase with occasional asynchronous resets mid-flight.
        for (int i = 0; i < 512; i++) begin
            mem[i] = 12'($urandom);
            az[i]  = 1'($urandom);
            r = $urandom_range(0, 99);
            if      (r < 58) kind[i] = K_NOP;
            else if (r < 64) kind[i] = K_GOTO;
            else if (r < 70) kind[i] = K_CALL;
            else if (r < 76) kind[i] = K_RET;
            else if (r < 79) kind[i] = K_SLEEP;
            else if (r < 85) kind[i] = K_FSZ;
            else if (r < 91) kind[i] = K_BTFSS;
            else if (r < 94) kind[i] = K_PCL;
            else if (r < 96) kind[i] = K_PCLSKIP;
            else             kind[i] = K_RAND;
        end
        rand_mode = 1'b1;
        apply_reset();
        for (int c = 0; c < 4000; c++) begin
            step();
            if (c % 1000 == 777) apply_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
